sgf_divider_seq: RTL and testbench
==================================

SGF_DIVIDER_SEQ -- requirements
Module: sgf_divider_seq

Interface
REQ-001 SHALL have parameter SW, default 54, giving the operand, quotient and remainder width in bits; legal range is 4..64.
REQ-002 SHALL have parameter precision, default 1, carried for FPU-family consistency (0 = single, 1 = double); it SHALL NOT change function.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start_i  input  1  request; sampled only when ready_o=1.
REQ-006 Data_A_i  input  SW  unsigned dividend; sampled on the accepting edge.
REQ-007 Data_B_i  input  SW  unsigned divisor; sampled on the accepting edge.
REQ-008 ready_o  output  1  block can accept start_i this cycle.
REQ-009 valid_o  output  1  result outputs hold a completed result.
REQ-010 sgf_result_o  output  SW  quotient floor(A/B).
REQ-011 rem_o  output  SW  remainder A mod B.
REQ-012 sticky_o  output  1  OR-reduction of rem_o (inexact flag for rounding).
REQ-013 div_zero_o  output  1  divisor was zero for the current result.

Function
REQ-014 SHALL implement a radix-2 restoring divider producing one quotient bit per clock, MSB first.
REQ-015 SHALL use FSM states IDLE, CALC, DONE; ready_o=1 in IDLE and DONE, 0 in CALC.
REQ-016 Acceptance is the rising edge with ready_o=1 and start_i=1; that edge registers A and B, clears partial remainder and quotient, loads counter=SW, clears valid_o, sticky_o and div_zero_o, and moves to CALC.
REQ-017 On each CALC edge: trial = {partial_rem[SW-1:0], next dividend MSB}; if trial >= B then rem=trial-B and q bit=1, else rem=trial and q bit=0; counter decrements by 1.
REQ-018 Partial remainder and trial subtractor SHALL be SW+1 bits wide so no carry is lost when B > 2^(SW-1).
REQ-019 After the SW-th CALC edge, FSM SHALL enter DONE with valid_o=1; latency is exactly SW rising edges after the accepting edge.
REQ-020 In DONE, sgf_result_o, rem_o, sticky_o and div_zero_o SHALL hold stable until the next acceptance; valid_o stays 1 until that acceptance.
REQ-021 Result outputs SHALL NOT change during CALC; they update only on the edge entering DONE.
REQ-022 Divide by zero (B=0 at acceptance): FSM goes IDLE->CALC->DONE with no iteration; on the first edge after acceptance it SHALL set sgf_result_o=all ones, rem_o=A, sticky_o=|A, div_zero_o=1, valid_o=1.
REQ-023 start_i during CALC SHALL be ignored with no effect on the running operation.
REQ-024 start_i=1 in DONE SHALL be accepted (back-to-back operation); valid_o falls on that edge.
REQ-025 Changes to Data_A_i or Data_B_i after acceptance SHALL NOT affect the result.
REQ-026 A < B SHALL give quotient 0 and remainder A; A = B SHALL give quotient 1 and remainder 0.
REQ-027 Iteration counter SHALL be $clog2(SW+1) bits wide and SHALL NOT wrap below 0.

Reset
REQ-028 rst=0 SHALL immediately and asynchronously force IDLE, ready_o=1, valid_o=0, sgf_result_o=0, rem_o=0, sticky_o=0, div_zero_o=0, counter=0.
REQ-029 Reset asserted during CALC SHALL abort the operation; no partial result SHALL become visible afterwards.
REQ-030 Release of rst SHALL take effect on the next rising edge; a start_i high on that edge SHALL be accepted.

Verification (SW=8 unless stated)
REQ-031 A=200, B=7, start 1 cycle -> exactly 8 edges later valid_o=1, quotient 28, rem 4, sticky 1, div_zero 0.
REQ-032 A=255, B=255 -> quotient 1, rem 0, sticky 0; then A=3, B=200 -> quotient 0, rem 3, sticky 1.
REQ-033 A=90, B=0 -> one edge later valid_o=1, quotient 8'hFF, rem 90, div_zero 1, sticky 1.
REQ-034 Start with A=100, B=9; pulse start_i with A=1, B=1 mid-CALC; drop rst at cycle 4 of a third run -> first run gives quotient 11, rem 1 and the mid-CALC start is ignored; the reset run returns to IDLE with all outputs 0.
REQ-035 SW=54, A=2^53+1, B=2^52+2^51 (normalized significands) -> quotient 1, rem 2^51+1, after 54 edges; back-to-back start in DONE accepted with no idle cycle.
REQ-036 Random regression: 10^5 operands in SW=8, 24, 54, compared against a reference model for quotient, remainder, sticky and latency.

Source files
------------

// File: rtl/sgf_divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : sgf_divider_seq
// Brief    : Sequential radix-2 restoring divider for significands.
//            Produces one quotient bit per clock, MSB first.
// Revision : 1.0  initial release
// ============================================================================
module sgf_divider_seq #(
    parameter int SW        = 54,
    parameter int precision = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [SW-1:0] Data_A_i,
    input  logic [SW-1:0] Data_B_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [SW-1:0] sgf_result_o,
    output logic [SW-1:0] rem_o,
    output logic          sticky_o,
    output logic          div_zero_o
);

    localparam int              c_CW       = $clog2(SW + 1);
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(SW);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    // precision only tags the instance within the FPU family; an illegal
    // configuration elaborates to an empty marker block
    if ((precision != 0 && precision != 1) || SW < 4 || SW > 64) begin : g_bad_cfg
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // r_a holds the dividend and collects quotient bits from the LSB side
    logic [SW-1:0]   r_a;
    logic [SW-1:0]   r_b;
    logic [SW:0]     r_rem;
    logic [c_CW-1:0] r_cnt;
    logic [SW-1:0]   r_result;
    logic [SW-1:0]   r_rem_out;
    logic            r_sticky;
    logic            r_dz;
    logic            r_valid;

    logic            w_ready;
    logic            w_accept;
    logic            w_finish;
    logic            w_b_zero;
    logic [SW:0]     w_trial;
    logic [SW:0]     w_diff;
    logic            w_ge;
    logic [SW:0]     w_rem_next;
    logic [SW-1:0]   w_quo_next;

    always_comb begin
        w_b_zero   = (r_b == '0);
        w_trial    = {r_rem[SW-1:0], r_a[SW-1]};
        w_diff     = w_trial - {1'b0, r_b};
        // a set top bit means the shifted value already exceeds any divisor
        w_ge       = r_rem[SW] | (w_trial >= {1'b0, r_b});
        w_rem_next = w_ge ? w_diff : w_trial;
        w_quo_next = {r_a[SW-2:0], w_ge};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b1;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start_i) begin
                    w_accept     = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                w_ready = 1'b0;
                if (w_b_zero || r_cnt == c_CNT_ONE) begin
                    w_finish     = 1'b1;
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_rem_out <= '0;
            r_sticky  <= 1'b0;
            r_dz      <= 1'b0;
            r_valid   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= Data_A_i;
            r_b      <= Data_B_i;
            r_rem    <= '0;
            r_cnt    <= c_CNT_LOAD;
            r_sticky <= 1'b0;
            r_dz     <= 1'b0;
            r_valid  <= 1'b0;
        end else if (r_state == CALC) begin
            if (w_b_zero) begin
                r_result  <= '1;
                r_rem_out <= r_a;
                r_sticky  <= |r_a;
                r_dz      <= 1'b1;
                r_valid   <= 1'b1;
                r_cnt     <= '0;
            end else begin
                r_a   <= w_quo_next;
                r_rem <= w_rem_next;
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                end
                if (w_finish) begin
                    r_result  <= w_quo_next;
                    r_rem_out <= w_rem_next[SW-1:0];
                    r_sticky  <= |w_rem_next;
                    r_valid   <= 1'b1;
                end
            end
        end
    end

    assign ready_o      = w_ready;
    assign valid_o      = r_valid;
    assign sgf_result_o = r_result;
    assign rem_o        = r_rem_out;
    assign sticky_o     = r_sticky;
    assign div_zero_o   = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_sgf_divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sgf_divider_seq
// Brief    : Self-checking bench for sgf_divider_seq at SW = 8, 24 and 54.
// Revision : 1.0  initial release
// ============================================================================
module tb_sgf_divider_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        s8 = 1'b0, s24 = 1'b0, s54 = 1'b0;
    logic [7:0]  a8 = '0,  b8 = '0;
    logic [23:0] a24 = '0, b24 = '0;
    logic [53:0] a54 = '0, b54 = '0;

    logic        rd8, vl8, sk8, dz8;
    logic [7:0]  q8, r8;
    logic        rd24, vl24, sk24, dz24;
    logic [23:0] q24, r24;
    logic        rd54, vl54, sk54, dz54;
    logic [53:0] q54, r54;

    sgf_divider_seq #(.SW(8), .precision(0)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(s8), .Data_A_i(a8), .Data_B_i(b8),
        .ready_o(rd8), .valid_o(vl8), .sgf_result_o(q8), .rem_o(r8),
        .sticky_o(sk8), .div_zero_o(dz8));

    sgf_divider_seq #(.SW(24), .precision(0)) u_dut24 (
        .clk(clk), .rst(rst), .start_i(s24), .Data_A_i(a24), .Data_B_i(b24),
        .ready_o(rd24), .valid_o(vl24), .sgf_result_o(q24), .rem_o(r24),
        .sticky_o(sk24), .div_zero_o(dz24));

    sgf_divider_seq #(.SW(54), .precision(1)) u_dut54 (
        .clk(clk), .rst(rst), .start_i(s54), .Data_A_i(a54), .Data_B_i(b54),
        .ready_o(rd54), .valid_o(vl54), .sgf_result_o(q54), .rem_o(r54),
        .sticky_o(sk54), .div_zero_o(dz54));

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    // last completed result per instance, as the bench expects it
    logic [63:0] last_q [3];
    logic [63:0] last_r [3];

    logic        o_rdy, o_val, o_sk, o_dz;
    logic [63:0] o_q, o_r;

    always_comb begin
        o_rdy = rd8; o_val = vl8; o_sk = sk8; o_dz = dz8;
        o_q = 64'(q8); o_r = 64'(r8);
        if (sel == 1) begin
            o_rdy = rd24; o_val = vl24; o_sk = sk24; o_dz = dz24;
            o_q = 64'(q24); o_r = 64'(r24);
        end else if (sel == 2) begin
            o_rdy = rd54; o_val = vl54; o_sk = sk54; o_dz = dz54;
            o_q = 64'(q54); o_r = 64'(r54);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s (SW sel %0d): got %0h expected %0h", tag, sel, obs, exp);
        end
    endtask

    function automatic int wid(input int w);
        return (w == 0) ? 8 : ((w == 1) ? 24 : 54);
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive(input logic s, input logic [63:0] a, input logic [63:0] b);
        case (sel)
            0:       begin s8  = s; a8  = a[7:0];  b8  = b[7:0];  end
            1:       begin s24 = s; a24 = a[23:0]; b24 = b[23:0]; end
            default: begin s54 = s; a54 = a[53:0]; b54 = b[53:0]; end
        endcase
    endtask

    // one division from the ready state through to the result
    task automatic run(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                       input bit poke, input bit sync);
        logic [63:0] m, a, b, eq, er;
        logic        es, ed;
        int          lat, exp_lat;
        sel = w;
        m   = (64'd1 << wid(w)) - 64'd1;
        a   = a_in & m;
        b   = b_in & m;
        if (b == 0) begin
            eq = m; er = a; ed = 1'b1; exp_lat = 1;
        end else begin
            eq = a / b; er = a % b; ed = 1'b0; exp_lat = wid(w);
        end
        es = (er != 0);
        if (sync) @(negedge clk);
        #1;
        chk("ready_before", 64'(o_rdy), 64'd1);
        drive(1'b1, a, b);
        @(posedge clk); #1;
        drive(1'b0, rnd64(), rnd64());
        lat = 0;
        while (!o_val && lat < 200) begin
            chk("calc_ready", 64'(o_rdy), 64'd0);
            chk("calc_q_hold", o_q, last_q[w]);
            chk("calc_r_hold", o_r, last_r[w]);
            chk("calc_sticky", 64'(o_sk), 64'd0);
            chk("calc_dz", 64'(o_dz), 64'd0);
            if (poke && lat == 3) drive(1'b1, 64'd1, 64'd1);
            else                  drive(1'b0, rnd64(), rnd64());
            @(posedge clk); #1;
            lat++;
        end
        drive(1'b0, rnd64(), rnd64());
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("quotient", o_q, eq);
        chk("remainder", o_r, er);
        chk("sticky", 64'(o_sk), 64'(es));
        chk("div_zero", 64'(o_dz), 64'(ed));
        chk("ready_done", 64'(o_rdy), 64'd1);
        last_q[w] = eq;
        last_r[w] = er;
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            chk("done_valid", 64'(o_val), 64'd1);
            chk("done_q", o_q, last_q[sel]);
            chk("done_r", o_r, last_r[sel]);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 64'(o_rdy), 64'd1);
        chk({tag, "_valid"}, 64'(o_val), 64'd0);
        chk({tag, "_q"}, o_q, 64'd0);
        chk({tag, "_r"}, o_r, 64'd0);
        chk({tag, "_sticky"}, 64'(o_sk), 64'd0);
        chk({tag, "_dz"}, 64'(o_dz), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            last_q[i] = '0;
            last_r[i] = '0;
        end
        #1;
        for (int w = 0; w < 3; w++) begin
            sel = w;
            #1;
            chk_reset_state("reset");
        end
        @(negedge clk);
        rst = 1'b1;

        // directed SW=8 cases
        run(0, 64'd200, 64'd7, 1'b0, 1'b1);
        hold(3);
        run(0, 64'd255, 64'd255, 1'b0, 1'b1);
        run(0, 64'd3, 64'd200, 1'b0, 1'b1);
        run(0, 64'd90, 64'd0, 1'b0, 1'b1);
        hold(2);
        run(0, 64'd100, 64'd9, 1'b1, 1'b1);
        hold(1);

        // reset during CALC aborts; release edge accepts a new start
        sel = 0;
        @(negedge clk);
        drive(1'b1, 64'd50, 64'd3);
        @(posedge clk); #1;
        drive(1'b0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_state("async_rst");
        for (int i = 0; i < 3; i++) begin
            last_q[i] = '0;
            last_r[i] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk_reset_state("rst_held");
        @(negedge clk);
        rst = 1'b1;
        run(0, 64'd20, 64'd6, 1'b0, 1'b0);

        // normalized significands, back-to-back in DONE
        run(2, (64'd1 << 53) | 64'd1, (64'd1 << 52) | (64'd1 << 51), 1'b0, 1'b1);
        run(2, (64'd1 << 53) - 64'd1, 64'd1 << 53, 1'b1, 1'b1);
        run(1, 64'hFFFFFF, 64'h800001, 1'b0, 1'b1);

        // randomized regression
        for (int w = 0; w < 3; w++) begin
            for (int n = 0; n < 200; n++) begin
                logic [63:0] a, b, m;
                int mode;
                m    = (64'd1 << wid(w)) - 64'd1;
                a    = rnd64() & m;
                mode = $urandom_range(0, 9);
                case (mode)
                    0:       b = 64'd0;
                    1:       b = 64'($urandom_range(1, 3));
                    2:       b = a;
                    3:       b = rnd64() | (64'd1 << (wid(w) - 1));
                    4:       b = rnd64() >> (64 - wid(w) / 2);
                    default: b = rnd64();
                endcase
                run(w, a, b, ($urandom_range(0, 3) == 0), 1'b1);
                if ($urandom_range(0, 7) == 0) hold($urandom_range(1, 3));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
